// File: rtl/rom_boot_pkg.sv
// -----------------------------------------------------------------------------
// rom_boot_pkg
// Shared definitions for the ROM boot copier:
//   - boot_state_t : sequencer states (FETCH, WRITE, DONE, ERROR)
//   - MAGIC_LEN    : number of header bytes that must match
//   - BOOT_MAGIC   : expected header bytes, "ASRM" (index 0 is the first ROM byte)
//   - magic_byte() : header byte lookup helper
// -----------------------------------------------------------------------------
package rom_boot_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } boot_state_t;

  localparam int MAGIC_LEN = 4;

  localparam logic [7:0] BOOT_MAGIC [MAGIC_LEN] = '{8'h41, 8'h53, 8'h52, 8'h4D};

  // Header byte at position idx; only meaningful for idx < MAGIC_LEN.
  function automatic logic [7:0] magic_byte(input int unsigned idx);
    return BOOT_MAGIC[idx % MAGIC_LEN];
  endfunction

endpackage : rom_boot_pkg

// File: rtl/boot_magic_checker.sv
// -----------------------------------------------------------------------------
// boot_magic_checker
// Purely combinational header check. While the copy index points into the
// header, the byte coming out of the ROM must equal BOOT_MAGIC[index].
//
// Ports:
//   index     in  IDX_W  current copy index
//   rom_data  in  8      byte read from the ROM for this index
//   in_header out 1      index lies inside the header
//   mismatch  out 1      index lies inside the header and the byte is wrong
// -----------------------------------------------------------------------------
module boot_magic_checker
  import rom_boot_pkg::*;
#(
  parameter int IDX_W = 9
) (
  input  logic [IDX_W-1:0] index,
  input  logic [7:0]       rom_data,
  output logic             in_header,
  output logic             mismatch
);

  // One match term per header position; at most one can be selected.
  logic [MAGIC_LEN-1:0] hit;

  generate
    for (genvar gi = 0; gi < MAGIC_LEN; gi++) begin : g_magic
      assign hit[gi] = (index == IDX_W'(gi)) && (rom_data == magic_byte(gi));
    end
  endgenerate

  assign in_header = (index < IDX_W'(MAGIC_LEN));
  assign mismatch  = in_header && (hit == '0);

endmodule : boot_magic_checker

// File: rtl/rom_boot_copier.sv
// -----------------------------------------------------------------------------
// rom_boot_copier
// Boot-time sequencer: validates the 4-byte "ASRM" header at the start of the
// program ROM, copies COPY_LEN ROM bytes into CPU RAM through a ready-handshaked
// write port, and keeps the CPU in reset until the copy has succeeded.
//
// Parameters:
//   ROM_ADDR_W  ROM address width (also the copy index width)
//   RAM_ADDR_W  RAM address width
//   COPY_LEN    bytes copied, ROM addresses 0..COPY_LEN-1 (4..2^ROM_ADDR_W)
//   RAM_BASE    RAM address receiving ROM byte 0
//
// Ports:
//   clk        in   1           system clock
//   reset      in   1           asynchronous, active-high reset
//   start      in   1           restart pulse, honoured only in DONE / ERROR
//   rom_enable out  1           ROM output enable
//   rom_addr   out  ROM_ADDR_W  ROM address
//   rom_data   in   8           ROM read data (one-cycle latency)
//   ram_addr   out  RAM_ADDR_W  RAM write address
//   ram_data   out  8           RAM write data
//   ram_we     out  1           RAM write request
//   ram_ready  in   1           RAM accepts when ram_we & ram_ready at an edge
//   checksum   out  8           mod-256 sum of accepted bytes
//                               (only with ROM_BOOT_COPIER_CHECKSUM_EN defined)
//   cpu_reset  out  1           holds the CPU in reset while high
//   done       out  1           copy completed (level)
//   error      out  1           header mismatch (level)
//
// Optional feature macro: ROM_BOOT_COPIER_CHECKSUM_EN
//
// Timing: each byte spends one cycle in FETCH (address presented) and one in
// WRITE (data valid, write requested), so an unstalled copy of N bytes reaches
// DONE 2N cycles after reset release. ram_we/ram_data are decoded from the
// WRITE state and the live ROM byte so the write is requested in the same cycle
// the data appears; all other outputs come straight from registers.
// -----------------------------------------------------------------------------
module rom_boot_copier
  import rom_boot_pkg::*;
#(
  parameter int                    ROM_ADDR_W = 9,
  parameter int                    RAM_ADDR_W = 16,
  parameter int                    COPY_LEN   = 387,
  parameter logic [RAM_ADDR_W-1:0] RAM_BASE   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rom_enable,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_we,
  input  logic                  ram_ready,
`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
  output logic [7:0]            checksum,
`endif
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [ROM_ADDR_W-1:0] LAST_IDX = ROM_ADDR_W'(COPY_LEN - 1);

  boot_state_t           state_reg;
  logic [ROM_ADDR_W-1:0] index_reg;
  logic [RAM_ADDR_W-1:0] ram_addr_reg;
  logic                  rom_enable_reg;
  logic                  cpu_reset_reg;
  logic                  done_reg;
  logic                  error_reg;

  logic in_header;
  logic magic_bad;
  logic in_write;
  logic write_accept;
  logic restart;

  boot_magic_checker #(
    .IDX_W (ROM_ADDR_W)
  ) u_magic (
    .index     (index_reg),
    .rom_data  (rom_data),
    .in_header (in_header),
    .mismatch  (magic_bad)
  );

  assign in_write     = (state_reg == WRITE);
  // A bad header byte suppresses the write request in the very cycle it is seen.
  assign write_accept = in_write && !magic_bad && ram_ready;
  assign restart      = start && ((state_reg == DONE) || (state_reg == ERROR));

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FETCH;
      index_reg      <= '0;
      ram_addr_reg   <= RAM_BASE;
      rom_enable_reg <= 1'b0;
      cpu_reset_reg  <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          // rom_addr already equals index; the ROM returns the byte next cycle.
          rom_enable_reg <= 1'b1;
          state_reg      <= WRITE;
        end

        WRITE: begin
          // rom_enable and rom_addr are left untouched so the ROM keeps
          // re-reading the same byte and rom_data stays put while stalled.
          if (magic_bad) begin
            state_reg      <= ERROR;
            rom_enable_reg <= 1'b0;
            error_reg      <= 1'b1;
          end else if (ram_ready) begin
            if (index_reg == LAST_IDX) begin
              state_reg      <= DONE;
              rom_enable_reg <= 1'b0;
              done_reg       <= 1'b1;
              cpu_reset_reg  <= 1'b0;
            end else begin
              state_reg    <= FETCH;
              index_reg    <= index_reg + 1'b1;
              // Wraps naturally at RAM_ADDR_W bits.
              ram_addr_reg <= ram_addr_reg + 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          if (start) begin
            state_reg      <= FETCH;
            index_reg      <= '0;
            ram_addr_reg   <= RAM_BASE;
            rom_enable_reg <= 1'b1;
            cpu_reset_reg  <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running mod-256 sum of every byte the RAM has accepted.
  // ---------------------------------------------------------------------------
  logic [7:0] checksum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_reg <= 8'h00;
    end else if (restart) begin
      checksum_reg <= 8'h00;
    end else if (write_accept) begin
      checksum_reg <= checksum_reg + rom_data;
    end
  end

  assign checksum = checksum_reg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rom_enable = rom_enable_reg;
  assign rom_addr   = index_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_we     = in_write && !magic_bad;
  assign ram_data   = in_write ? rom_data : 8'h00;
  assign cpu_reset  = cpu_reset_reg;
  assign done       = done_reg;
  assign error      = error_reg;

  // The header indication is only needed for the mismatch term inside the
  // checker; it is kept on the checker interface for debug visibility.
  logic unused_ok;
  assign unused_ok = in_header ^ write_accept ^ restart;

endmodule : rom_boot_copier

// File: tb/tb_rom_boot_copier.sv
// -----------------------------------------------------------------------------
// tb_rom_boot_copier
// Drives rom_boot_copier with a behavioural synchronous ROM and a RAM slave
// that stalls according to a per-byte plan. Expected RAM contents, write
// order, completion time (2 cycles per byte plus planned stalls) and checksum
// are derived from the ROM image and the stall plan.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rom_boot_copier;

  localparam int          ROM_ADDR_W = 9;
  localparam int          RAM_ADDR_W = 16;
  localparam int          N          = 387;
  localparam logic [15:0] BASE       = 16'h0000;
  localparam int          BUDGET     = 4000;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  ram_ready = 1'b1;
  logic                  rom_enable;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [7:0]            rom_data;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [7:0]            ram_data;
  logic                  ram_we;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;
`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
  logic [7:0]            checksum;
`endif

  rom_boot_copier #(
    .ROM_ADDR_W (ROM_ADDR_W),
    .RAM_ADDR_W (RAM_ADDR_W),
    .COPY_LEN   (N),
    .RAM_BASE   (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rom_enable (rom_enable),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .ram_ready  (ram_ready),
`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_viol = 0;

  // Synchronous ROM: registered read every cycle, output gated by enable.
  logic [7:0] rom_mem [512];
  logic [7:0] rom_q;
  always @(posedge clk) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_enable ? rom_q : 8'h00;

  // Number of cycles the RAM holds ram_ready low for each byte.
  int stall_plan [N];

  // Accepted writes, in order.
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wr_q[$];

  always @(posedge clk) begin
    if (!reset && ram_we && ram_ready) wr_q.push_back({ram_addr, ram_data});
    if (done && error) n_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_sum();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < N; i++) s = s + rom_mem[i];
    return s;
  endfunction

  function automatic int plan_total();
    int t;
    t = 0;
    for (int i = 0; i < N; i++) t += stall_plan[i];
    return t;
  endfunction

  task automatic load_valid_rom(input bit randomize);
    for (int i = 0; i < 512; i++) rom_mem[i] = randomize ? 8'($urandom) : 8'(i * 7 + 3);
    rom_mem[0] = 8'h41; rom_mem[1] = 8'h53; rom_mem[2] = 8'h52; rom_mem[3] = 8'h4D;
    rom_mem[N-1] = 8'h3E;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < N; i++) stall_plan[i] = 0;
  endtask

  // Ends at a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    wr_q.delete();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    $display("[%0t] %s: reset values", $time, tag);
    chk("rst_rom_enable", 32'(rom_enable), 32'(0));
    chk("rst_rom_addr",   32'(rom_addr),   32'(0));
    chk("rst_ram_we",     32'(ram_we),     32'(0));
    chk("rst_ram_addr",   32'(ram_addr),   32'(BASE));
    chk("rst_ram_data",   32'(ram_data),   32'(0));
    chk("rst_cpu_reset",  32'(cpu_reset),  32'(1));
    chk("rst_done",       32'(done),       32'(0));
    chk("rst_error",      32'(error),      32'(0));
`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
    chk("rst_checksum",   32'(checksum),   32'(0));
`endif
  endtask

  // Called at a negedge. Acts as the RAM slave until done/error, until
  // stop_at writes have been accepted, or until the cycle budget runs out.
  // Returns just after a posedge.
  task automatic run_copy(input int start_at, input int stop_at,
                          output int cycles, output bit finished);
    int  stall_cnt;
    int  k;
    int  last_n;
    bit  started;
    stall_cnt = 0;
    started   = 1'b0;
    cycles    = 0;
    finished  = 1'b0;
    while (cycles < BUDGET) begin
      start = 1'b0;
      if (ram_we === 1'b1) begin
        k = wr_q.size();
        if (k < N && stall_cnt < stall_plan[k]) begin
          ram_ready = 1'b0;
          stall_cnt++;
          chk("stall_addr", 32'(ram_addr), 32'(16'(BASE + k)));
          chk("stall_data", 32'(ram_data), 32'(rom_mem[k]));
        end else begin
          ram_ready = 1'b1;
        end
        if (!started && k == start_at) begin
          start   = 1'b1;
          started = 1'b1;
        end
      end else begin
        ram_ready = 1'($urandom_range(0, 1));
      end
      last_n = wr_q.size();
      @(posedge clk);
      #1;
      cycles++;
      if (wr_q.size() != last_n) stall_cnt = 0;
      if (done || error) begin
        finished = 1'b1;
        break;
      end
      if (stop_at >= 0 && wr_q.size() == stop_at) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic verify_image(input string tag);
    int fb;
    fb = 0;
    for (int i = 0; i < wr_q.size() && i < N; i++) begin
      if (wr_q[i].a !== 16'(BASE + i) || wr_q[i].d !== rom_mem[i]) begin
        fb = i;
        break;
      end
    end
    $display("[%0t] %s: %0d writes, first checked index %0d", $time, tag, wr_q.size(), fb);
    chk("image_count", 32'(wr_q.size()), 32'(N));
    if (wr_q.size() > fb) begin
      chk("image_addr", 32'(wr_q[fb].a), 32'(16'(BASE + fb)));
      chk("image_data", 32'(wr_q[fb].d), 32'(rom_mem[fb]));
    end
  endtask

  task automatic check_done(input string tag, input int cycles, input int exp_cycles,
                            input bit finished);
    $display("[%0t] %s: finished=%0d cycles=%0d (expect %0d)", $time, tag, finished, cycles, exp_cycles);
    chk("done_finished",   32'(finished),   32'(1));
    chk("done_cycles",     32'(cycles),     32'(exp_cycles));
    chk("done_level",      32'(done),       32'(1));
    chk("done_error",      32'(error),      32'(0));
    chk("done_cpu_reset",  32'(cpu_reset),  32'(0));
    chk("done_rom_enable", 32'(rom_enable), 32'(0));
    chk("done_ram_we",     32'(ram_we),     32'(0));
`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
    chk("done_checksum",   32'(checksum),   32'(rom_sum()));
`endif
  endtask

  // Called after a posedge; returns at a negedge just after the start edge.
  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    $display("[%0t] %s: start pulse", $time, tag);
    chk("start_done",      32'(done),      32'(0));
    chk("start_error",     32'(error),     32'(0));
    chk("start_cpu_reset", 32'(cpu_reset), 32'(1));
`ifdef ROM_BOOT_COPIER_CHECKSUM_EN
    chk("start_checksum",  32'(checksum),  32'(0));
`endif
    @(negedge clk);
    start = 1'b0;
    wr_q.delete();
  endtask

  initial begin
    int cycles;
    bit finished;
    int plan_sum;

    // ---- Reset state ----
    load_valid_rom(1'b0);
    clear_plan();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("power_on");

    // ---- Valid image, RAM always ready ----
    wr_q.delete();
    reset = 1'b0;
    run_copy(-1, -1, cycles, finished);
    check_done("valid_copy", cycles, 2 * N, finished);
    verify_image("valid_copy");
    if (wr_q.size() == N) chk("ram_0x182", 32'(wr_q[16'h182].d), 32'(8'h3E));

    // ---- Start in DONE: restart and full recopy ----
    pulse_start("restart_from_done");
    run_copy(-1, -1, cycles, finished);
    check_done("recopy", cycles, 2 * N, finished);
    verify_image("recopy");

    // ---- 5-cycle stall on byte 10, start ignored at index 50 ----
    clear_plan();
    stall_plan[10] = 5;
    do_reset();
    run_copy(50, -1, cycles, finished);
    check_done("stall_and_ignored_start", cycles, 2 * N + 5, finished);
    verify_image("stall_and_ignored_start");

    // ---- Reset mid-copy at index 200 ----
    clear_plan();
    do_reset();
    run_copy(-1, 200, cycles, finished);
    chk("mid_reset_progress", 32'(wr_q.size()), 32'(200));
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("mid_copy_reset");
    @(negedge clk);
    wr_q.delete();
    reset = 1'b0;
    run_copy(-1, -1, cycles, finished);
    check_done("after_mid_reset", cycles, 2 * N, finished);
    if (wr_q.size() > 0) begin
      chk("first_write_addr", 32'(wr_q[0].a), 32'(BASE));
      chk("first_write_data", 32'(wr_q[0].d), 32'(8'h41));
    end
    verify_image("after_mid_reset");

    // ---- Corrupted header byte 1 ----
    rom_mem[1] = 8'h54;
    do_reset();
    run_copy(-1, -1, cycles, finished);
    $display("[%0t] bad_header: finished=%0d cycles=%0d writes=%0d", $time, finished, cycles, wr_q.size());
    chk("bad_finished",   32'(finished),    32'(1));
    chk("bad_cycles",     32'(cycles),      32'(4));
    chk("bad_writes",     32'(wr_q.size()), 32'(1));
    if (wr_q.size() > 0) begin
      chk("bad_write_addr", 32'(wr_q[0].a), 32'(BASE));
      chk("bad_write_data", 32'(wr_q[0].d), 32'(8'h41));
    end
    chk("bad_error",      32'(error),      32'(1));
    chk("bad_cpu_reset",  32'(cpu_reset),  32'(1));
    chk("bad_done",       32'(done),       32'(0));
    chk("bad_rom_enable", 32'(rom_enable), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("bad_error_held", 32'(error),      32'(1));

    // ---- Restart from ERROR with a repaired image ----
    rom_mem[1] = 8'h53;
    pulse_start("restart_from_error");
    run_copy(-1, -1, cycles, finished);
    check_done("recopy_after_error", cycles, 2 * N, finished);
    verify_image("recopy_after_error");

    // ---- Random image, random stalls, ignored start at random index ----
    for (int r = 0; r < 2; r++) begin
      load_valid_rom(1'b1);
      for (int i = 0; i < N; i++) stall_plan[i] = int'($urandom_range(0, 3));
      plan_sum = plan_total();
      do_reset();
      run_copy(int'($urandom_range(5, N - 2)), -1, cycles, finished);
      check_done("random_copy", cycles, 2 * N + plan_sum, finished);
      verify_image("random_copy");
    end

    chk("done_error_exclusive", 32'(n_viol), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rom_boot_copier
